// File: rtl/bus_rr.sv
// Round-robin multi-host to multi-device bus with address decode and one-cycle response.
// Optional BUS_RR_ERR_RESP_EN: decode misses are answered by the bus with an error response.
module bus_rr #(
  parameter int NrHosts      = 2,
  parameter int NrDevices    = 4,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NrHosts-1:0]        host_req_i,
  output logic [NrHosts-1:0]        host_gnt_o,
  input  logic [AddressWidth-1:0]   host_addr_i [NrHosts],
  input  logic [NrHosts-1:0]        host_we_i,
  input  logic [DataWidth/8-1:0]    host_be_i [NrHosts],
  input  logic [DataWidth-1:0]      host_wdata_i [NrHosts],
  output logic [NrHosts-1:0]        host_rvalid_o,
  output logic [NrHosts-1:0]        host_err_o,
  output logic [DataWidth-1:0]      host_rdata_o [NrHosts],
  output logic [NrDevices-1:0]      device_req_o,
  input  logic [NrDevices-1:0]      device_gnt_i,
  output logic [AddressWidth-1:0]   device_addr_o [NrDevices],
  output logic [NrDevices-1:0]      device_we_o,
  output logic [DataWidth/8-1:0]    device_be_o [NrDevices],
  output logic [DataWidth-1:0]      device_wdata_o [NrDevices],
  input  logic [DataWidth-1:0]      device_rdata_i [NrDevices],
  input  logic [AddressWidth-1:0]   cfg_device_addr_base [NrDevices],
  input  logic [AddressWidth-1:0]   cfg_device_addr_mask [NrDevices]
);

  localparam int HW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int DW = (NrDevices > 1) ? $clog2(NrDevices) : 1;

  logic [HW-1:0]        r_rr;
  logic [HW-1:0]        r_host;
  logic [DW-1:0]        r_dev;
  logic                 r_rvalid;
  logic                 r_we;
  logic [HW-1:0]        w_win;
  logic [HW-1:0]        w_rr_nxt;
  logic [DW-1:0]        w_dev;
  logic                 w_any;
  logic                 w_hit;
  logic                 w_route;
  logic                 w_gnt;
  logic [DataWidth-1:0] w_rdata;
`ifdef BUS_RR_ERR_RESP_EN
  logic                 r_err;
`endif

  function automatic logic [HW-1:0] wrap(input int v);
    int t;
    t = v % NrHosts;
    return HW'(t);
  endfunction

  // Scan downward so the host closest to the pointer is assigned last and wins.
  always_comb begin : p_arb
    logic [HW-1:0] idx;
    w_any = 1'b0;
    w_win = '0;
    idx   = '0;
    for (int i = NrHosts - 1; i >= 0; i--) begin
      idx = wrap(int'(r_rr) + i);
      if (host_req_i[idx]) begin
        w_any = 1'b1;
        w_win = idx;
      end
    end
    w_rr_nxt = wrap(int'(w_win) + 1);
  end

  always_comb begin
    w_hit = 1'b0;
    w_dev = '0;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if ((host_addr_i[w_win] & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) begin
        w_hit = 1'b1;
        w_dev = DW'(d);
      end
    end
  end

`ifdef BUS_RR_ERR_RESP_EN
  assign w_route = w_hit;
  assign w_gnt   = w_any & (w_hit ? device_gnt_i[w_dev] : 1'b1);
`else
  // A miss leaves w_dev at 0, so it simply lands on device 0.
  assign w_route = 1'b1;
  assign w_gnt   = w_any & device_gnt_i[w_dev];
`endif

  always_comb begin
    for (int d = 0; d < NrDevices; d++) begin
      device_req_o[d]   = w_any & w_route & (w_dev == DW'(d));
      device_addr_o[d]  = device_req_o[d] ? host_addr_i[w_win]  : '0;
      device_we_o[d]    = device_req_o[d] & host_we_i[w_win];
      device_be_o[d]    = device_req_o[d] ? host_be_i[w_win]    : '0;
      device_wdata_o[d] = device_req_o[d] ? host_wdata_i[w_win] : '0;
    end
    for (int h = 0; h < NrHosts; h++) begin
      host_gnt_o[h] = w_gnt & (w_win == HW'(h));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr     <= '0;
      r_rvalid <= 1'b0;
      r_host   <= '0;
      r_dev    <= '0;
      r_we     <= 1'b0;
`ifdef BUS_RR_ERR_RESP_EN
      r_err    <= 1'b0;
`endif
    end else begin
      r_rvalid <= w_gnt;
      if (w_gnt) begin
        r_rr   <= w_rr_nxt;
        r_host <= w_win;
        r_dev  <= w_dev;
        r_we   <= host_we_i[w_win];
`ifdef BUS_RR_ERR_RESP_EN
        r_err  <= ~w_hit;
`endif
      end
    end
  end

  always_comb begin
    w_rdata = r_we ? '0 : device_rdata_i[r_dev];
`ifdef BUS_RR_ERR_RESP_EN
    if (r_err) w_rdata = '1;
`endif
    for (int h = 0; h < NrHosts; h++) begin
      host_rvalid_o[h] = r_rvalid & (r_host == HW'(h));
      host_rdata_o[h]  = host_rvalid_o[h] ? w_rdata : '0;
`ifdef BUS_RR_ERR_RESP_EN
      host_err_o[h]    = host_rvalid_o[h] & r_err;
`else
      host_err_o[h]    = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_bus_rr.sv
// Scoreboard bench for bus_rr: stimulus pushes expected responses, a negedge monitor pops them.
module tb_bus_rr;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, gnt, we, rvalid, err;
  logic [31:0] addr [2];
  logic [3:0]  be [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata_o [2];
  logic [3:0]  dev_req, dev_gnt, dev_we;
  logic [31:0] dev_addr [4];
  logic [3:0]  dev_be [4];
  logic [31:0] dev_wdata [4];
  logic [31:0] dev_rdata [4];
  logic [31:0] base [4];
  logic [31:0] mask [4];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          host;
    logic [31:0] rdata;
    logic        err;
  } resp_t;
  resp_t q[$];
  resp_t mon_e;

  bus_rr dut (
    .clk_i(clk), .rst_i(rst),
    .host_req_i(req), .host_gnt_o(gnt), .host_addr_i(addr), .host_we_i(we),
    .host_be_i(be), .host_wdata_i(wdata), .host_rvalid_o(rvalid), .host_err_o(err),
    .host_rdata_o(rdata_o),
    .device_req_o(dev_req), .device_gnt_i(dev_gnt), .device_addr_o(dev_addr),
    .device_we_o(dev_we), .device_be_o(dev_be), .device_wdata_o(dev_wdata),
    .device_rdata_i(dev_rdata),
    .cfg_device_addr_base(base), .cfg_device_addr_mask(mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // One bus cycle: drive requests, check combinational grant/forwarding, queue expected response.
  task automatic step(input logic [1:0] r, input int ew, input bit eg, input int edev,
                      input bit push, input logic [31:0] erd, input logic eerr);
    logic [1:0] egv;
    logic [3:0] edv;
    req = r;
    @(negedge clk);
    #1;
    egv = 2'b00;
    if (eg) egv[ew] = 1'b1;
    edv = 4'b0000;
    if (edev >= 0) edv[edev] = 1'b1;
    chk("host_gnt", {30'b0, gnt}, {30'b0, egv});
    chk("device_req", {28'b0, dev_req}, {28'b0, edv});
    for (int d = 0; d < 4; d++) begin
      if (d == edev) begin
        chk("dev_addr", dev_addr[d], addr[ew]);
        chk("dev_wdata", dev_wdata[d], wdata[ew]);
        chk("dev_we_be", {27'b0, dev_we[d], dev_be[d]}, {27'b0, we[ew], be[ew]});
      end else begin
        chk("dev_idle", dev_addr[d] | dev_wdata[d] | {27'b0, dev_we[d], dev_be[d]}, 32'h0);
      end
    end
    if (push) q.push_back('{ew, erd, eerr});
    @(posedge clk);
    #1;
  endtask

  // Every queued response must show up at the very next negedge on exactly its host.
  always @(negedge clk) begin
    if (!rst) begin
      if (rvalid != 2'b00 || q.size() != 0) begin
        if (q.size() == 0) begin
          chk("unexpected_rvalid", {30'b0, rvalid}, 32'h0);
        end else begin
          mon_e = q.pop_front();
          chk("rvalid_host", {30'b0, rvalid}, (mon_e.host == 0) ? 32'h1 : 32'h2);
          chk("rdata", rdata_o[mon_e.host], mon_e.rdata);
          chk("err", {31'b0, err[mon_e.host]}, {31'b0, mon_e.err});
        end
      end
      for (int h = 0; h < 2; h++) begin
        if (!rvalid[h]) chk("idle_resp", rdata_o[h] | {31'b0, err[h]}, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req = 2'b00;
    we  = 2'b00;
    for (int h = 0; h < 2; h++) begin
      addr[h] = 32'h0; be[h] = 4'hF; wdata[h] = 32'h0;
    end
    dev_gnt = 4'hF;
    base[0] = 32'h0000_4000; mask[0] = 32'hFFFF_F000;
    base[1] = 32'h0000_1000; mask[1] = 32'h0000_F000;
    base[2] = 32'h0000_2000; mask[2] = 32'hFFFF_F000;
    base[3] = 32'h0000_2000; mask[3] = 32'h0000_F000;
    dev_rdata[0] = 32'hD000_0000;
    dev_rdata[1] = 32'hCAFE_F00D;
    dev_rdata[2] = 32'hD222_2222;
    dev_rdata[3] = 32'hD333_3333;

    #2;
    chk("reset_rvalid", {30'b0, rvalid}, 32'h0);
    chk("reset_rdata", rdata_o[0] | rdata_o[1], 32'h0);
    chk("reset_err", {30'b0, err}, 32'h0);
    addr[0] = 32'h0000_1000;
    req = 2'b01;
    #1;
    chk("reset_comb_gnt", {30'b0, gnt}, 32'h1);
    chk("reset_comb_dev_req", {28'b0, dev_req}, 32'h2);
    req = 2'b00;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Both hosts hammer device 1: strict alternation starting at host 0.
    addr[0] = 32'h0000_1000;
    addr[1] = 32'h0000_1004;
    for (int k = 0; k < 6; k++) step(2'b11, k % 2, 1'b1, 1, 1'b1, 32'hCAFE_F00D, 1'b0);

    step(2'b01, 0, 1'b1, 1, 1'b1, 32'hCAFE_F00D, 1'b0);

    // Pointer now at host 1; stall device 1 and make sure host 0 cannot slip in.
    addr[0] = 32'h0000_2000;
    dev_gnt = 4'b1101;
    for (int k = 0; k < 3; k++) step(2'b11, 1, 1'b0, 1, 1'b0, 32'h0, 1'b0);
    dev_gnt = 4'hF;
    step(2'b11, 1, 1'b1, 1, 1'b1, 32'hCAFE_F00D, 1'b0);

    // Overlapping windows: lowest index wins, otherwise the higher one decodes.
    step(2'b01, 0, 1'b1, 2, 1'b1, 32'hD222_2222, 1'b0);
    addr[0] = 32'h1200_2000;
    step(2'b01, 0, 1'b1, 3, 1'b1, 32'hD333_3333, 1'b0);

    // Back-to-back write then read to device 2.
    addr[0] = 32'h0000_2010; we[0] = 1'b1; wdata[0] = 32'h1234_5678; be[0] = 4'h3;
    step(2'b01, 0, 1'b1, 2, 1'b1, 32'h0, 1'b0);
    addr[0] = 32'h0000_2014; we[0] = 1'b0; wdata[0] = 32'h0; be[0] = 4'hF;
    step(2'b01, 0, 1'b1, 2, 1'b1, 32'hD222_2222, 1'b0);
    step(2'b00, 0, 1'b0, -1, 1'b0, 32'h0, 1'b0);

    addr[0] = 32'hF000_0000;
`ifdef BUS_RR_ERR_RESP_EN
    step(2'b01, 0, 1'b1, -1, 1'b1, 32'hFFFF_FFFF, 1'b1);
`else
    step(2'b01, 0, 1'b1, 0, 1'b1, 32'hD000_0000, 1'b0);
`endif
    step(2'b00, 0, 1'b0, -1, 1'b0, 32'h0, 1'b0);

    // Grant to host 0 (pointer -> 1), then reset before its response is seen.
    addr[0] = 32'h0000_1000;
    step(2'b01, 0, 1'b1, 1, 1'b0, 32'h0, 1'b0);
    req = 2'b00;
    rst = 1'b1;
    #1;
    chk("rst_drop_rvalid", {30'b0, rvalid}, 32'h0);
    chk("rst_drop_rdata", rdata_o[0], 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(2'b11, 0, 1'b1, 1, 1'b1, 32'hCAFE_F00D, 1'b0);
    step(2'b00, 0, 1'b0, -1, 1'b0, 32'h0, 1'b0);
    step(2'b00, 0, 1'b0, -1, 1'b0, 32'h0, 1'b0);

    chk("queue_empty", q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
